// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: timed sprinkler/drip scheduler with synchronised, debounced tank
// levels, inlet hysteresis and latched faults. Optional manual start: define IRRIG_MANUAL_EN.
module irrigation_sequencer #(
  parameter int TICK_DIV       = 50000,
  parameter int DEB_CYCLES     = 4,
  parameter int SPRINKLE_TICKS = 20,
  parameter int DRIP_TICKS     = 40,
  parameter int SOAK_TICKS     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       high,
  input  logic       middle,
  input  logic       low,
  input  logic       umidadeDoSolo,
  input  logic       umidadeDoAr,
  input  logic       temperatura,
  input  logic       enable,
`ifdef IRRIG_MANUAL_EN
  input  logic       manual_start,
`endif
  output logic       valve_sprinkler,
  output logic       valve_drip,
  output logic       valve_inlet,
  output logic       alarm,
  output logic       fault,
  output logic [2:0] state_code,
  output logic [7:0] cycle_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [7:0]    SPRINKLE_T = 8'(SPRINKLE_TICKS);
  localparam logic [7:0]    DRIP_T     = 8'(DRIP_TICKS);
  localparam logic [7:0]    SOAK_T     = 8'(SOAK_TICKS);
  // FAULT reuses the phase timer: the second consistent tick is one full tick after the first.
  localparam logic [7:0]    FAULT_T    = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_SOAK     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  // Sensor bit order: 0 low, 1 middle, 2 high, 3 soil dry, 4 temperature high, 5 air dry.
  logic [5:0]         sens_raw, sync1_q, sync2_q;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick;
  logic [2:0]         lvl_q, lvl_d;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  assign sens_raw = {umidadeDoAr, temperatura, umidadeDoSolo, high, middle, low};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    tick      = (pre_q == PRE_LAST);
    pre_d     = tick ? '0 : pre_q + PW'(1);
    lvl_d     = lvl_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) lvl_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of order.
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      lvl_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sens_raw;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      lvl_q     <= lvl_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  logic lvl_l, lvl_m, lvl_h, soil_dry, temp_hi, incons;
  logic unused_air;

  assign lvl_l      = lvl_q[0];
  assign lvl_m      = lvl_q[1];
  assign lvl_h      = lvl_q[2];
  assign soil_dry   = sync2_q[3];
  assign temp_hi    = sync2_q[4];
  // Air humidity is sampled for the downstream encoder but does not steer scheduling.
  assign unused_air = sync2_q[5];
  assign incons     = (lvl_h && !lvl_m) || (lvl_m && !lvl_l);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] count_q, count_d;
  logic       sprinkler_q, sprinkler_d;
  logic       drip_q, drip_d;
  logic       inlet_q, inlet_d;
  logic       alarm_q, alarm_d;
  logic       fault_q, fault_d;
  logic       start_auto, start_man, soil_exempt;

  assign start_auto = enable && soil_dry && lvl_l && !incons;

`ifdef IRRIG_MANUAL_EN
  logic man_s1_q, man_s2_q, man_prev_q, manual_q, manual_d;

  assign start_man   = enable && man_s2_q && !man_prev_q && lvl_l && !incons;
  assign soil_exempt = manual_q;

  // The soil-wet exemption lives only as long as the manually started phase.
  always_comb begin
    manual_d = manual_q;
    if (state_q == ST_IDLE) manual_d = start_man;
    if (state_d != ST_SPRINKLE && state_d != ST_DRIP) manual_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man_s1_q   <= 1'b0;
      man_s2_q   <= 1'b0;
      man_prev_q <= 1'b0;
      manual_q   <= 1'b0;
    end else begin
      man_s1_q   <= manual_start;
      man_s2_q   <= man_s1_q;
      man_prev_q <= man_s2_q;
      manual_q   <= manual_d;
    end
  end
`else
  assign start_man   = 1'b0;
  assign soil_exempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start_auto || start_man) begin
          if (temp_hi || !lvl_m) begin
            state_d = ST_DRIP;
            timer_d = DRIP_T;
          end else begin
            state_d = ST_SPRINKLE;
            timer_d = SPRINKLE_T;
          end
        end
      end
      ST_SPRINKLE, ST_DRIP: begin
        if (!lvl_l || !enable) begin
          state_d = ST_IDLE;
        end else if ((tick && timer_q == 8'd1) || (!soil_dry && !soil_exempt)) begin
          state_d = ST_SOAK;
          timer_d = SOAK_T;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      ST_SOAK, ST_FAULT: begin
        if (tick) begin
          if (timer_q == 8'd1) state_d = ST_IDLE;
          else                 timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inconsistent levels override everything, including a cycle completing on this edge.
    if (incons) begin
      state_d = ST_FAULT;
      timer_d = FAULT_T;
      count_d = count_q;
    end

    sprinkler_d = (state_d == ST_SPRINKLE);
    drip_d      = (state_d == ST_DRIP);
    fault_d     = (state_d == ST_FAULT);
    alarm_d     = !lvl_l || fault_d;
    if (fault_d || lvl_h) inlet_d = 1'b0;
    else if (!lvl_m)      inlet_d = 1'b1;
    else                  inlet_d = inlet_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      sprinkler_q <= 1'b0;
      drip_q      <= 1'b0;
      inlet_q     <= 1'b0;
      alarm_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      sprinkler_q <= sprinkler_d;
      drip_q      <= drip_d;
      inlet_q     <= inlet_d;
      alarm_q     <= alarm_d;
      fault_q     <= fault_d;
    end
  end

  assign valve_sprinkler = sprinkler_q;
  assign valve_drip      = drip_q;
  assign valve_inlet     = inlet_q;
  assign alarm           = alarm_q;
  assign fault           = fault_q;
  assign state_code      = state_q;
  assign cycle_count     = count_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer: directed scenarios plus randomised stimulus,
// compared every cycle against a tick-counting behavioural model.
module tb_irrigation_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 2;
  localparam int SPR      = 3;
  localparam int DRP      = 5;
  localparam int SOAK     = 2;

  localparam int S_IDLE  = 0;
  localparam int S_SPR   = 1;
  localparam int S_DRIP  = 2;
  localparam int S_SOAK  = 3;
  localparam int S_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       high = 1'b0, middle = 1'b0, low = 1'b0;
  logic       soil = 1'b0, air = 1'b0, temp = 1'b0, enable = 1'b0;
  logic       valve_sprinkler, valve_drip, valve_inlet, alarm, fault;
  logic [2:0] state_code;
  logic [7:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  irrigation_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .DEB_CYCLES    (DEB),
    .SPRINKLE_TICKS(SPR),
    .DRIP_TICKS    (DRP),
    .SOAK_TICKS    (SOAK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .high           (high),
    .middle         (middle),
    .low            (low),
    .umidadeDoSolo  (soil),
    .umidadeDoAr    (air),
    .temperatura    (temp),
    .enable         (enable),
    .valve_sprinkler(valve_sprinkler),
    .valve_drip     (valve_drip),
    .valve_inlet    (valve_inlet),
    .alarm          (alarm),
    .fault          (fault),
    .state_code     (state_code),
    .cycle_count    (cycle_count)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: levels accepted once the last DEB synchronised samples all disagree
  // with the accepted value; phases end when the count of ticks since entry reaches their length.
  int       m_state, m_ticks, m_edges, m_count;
  bit       m_inlet, m_alarm;
  bit [2:0] m_deb;
  bit [5:0] m_hist [0:DEB];

  function automatic int phase_len(input int st);
    case (st)
      S_SPR:   return SPR;
      S_DRIP:  return DRP;
      S_SOAK:  return SOAK;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_ticks = 0;
    m_edges = 0;
    m_count = 0;
    m_inlet = 1'b0;
    m_alarm = 1'b0;
    m_deb   = '0;
    for (int k = 0; k <= DEB; k++) m_hist[k] = '0;
  endtask

  task automatic model_step();
    bit h, m, l, soil_s, temp_s, tick, incons, all_new;
    int nxt;
    h      = m_deb[2];
    m      = m_deb[1];
    l      = m_deb[0];
    soil_s = m_hist[1][3];
    temp_s = m_hist[1][4];
    tick   = (m_edges % TICK_DIV) == TICK_DIV - 1;
    m_edges++;
    if (tick) m_ticks++;
    incons = (h && !m) || (m && !l);
    nxt    = m_state;
    if (incons) begin
      nxt = S_FAULT;
    end else begin
      case (m_state)
        S_IDLE: if (enable && soil_s && l) nxt = (temp_s || !m) ? S_DRIP : S_SPR;
        S_SPR, S_DRIP: begin
          if (!l || !enable) nxt = S_IDLE;
          else if (m_ticks == phase_len(m_state) || !soil_s) begin
            nxt = S_SOAK;
            if (m_count < 255) m_count++;
          end
        end
        default: if (m_ticks == phase_len(m_state)) nxt = S_IDLE;
      endcase
    end
    if (nxt != m_state || incons) m_ticks = 0;
    if (nxt == S_FAULT || h) m_inlet = 1'b0;
    else if (!m)             m_inlet = 1'b1;
    m_alarm = !l || (nxt == S_FAULT);
    m_state = nxt;
    for (int b = 0; b < 3; b++) begin
      all_new = 1'b1;
      for (int k = 1; k <= DEB; k++) if (m_hist[k][b] == m_deb[b]) all_new = 1'b0;
      if (all_new) m_deb[b] = ~m_deb[b];
    end
    for (int k = DEB; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = {air, temp, soil, high, middle, low};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [15:0] act, exp;
    @(negedge clk);
    if (rst_n) begin
      act = {fault, alarm, valve_inlet, valve_drip, valve_sprinkler, state_code, cycle_count};
      exp = {(m_state == S_FAULT), m_alarm, m_inlet, (m_state == S_DRIP), (m_state == S_SPR),
             3'(m_state), 8'(m_count)};
      check("cycle_outputs", int'(act), int'(exp));
    end
  end

  task automatic wait_state(input int code, input int budget, input string name);
    int n = 0;
    while (int'(state_code) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_code), code);
  endtask

  task automatic wait_inlet(input bit val, input int budget, input string name);
    int n = 0;
    while (valve_inlet != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(valve_inlet), int'(val));
  endtask

  function automatic int all_outs();
    return int'({fault, alarm, valve_inlet, valve_drip, valve_sprinkler, state_code, cycle_count});
  endfunction

  initial begin
    int n;
    bit seen;
    logic [2:0] lv;
    logic [2:0] pats [4];
    pats = '{3'b000, 3'b001, 3'b011, 3'b111};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    check("reset_state", int'(state_code), S_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sprinkle cycle
    {high, middle, low} = 3'b111;
    soil = 1'b1; temp = 1'b0; enable = 1'b1;
    wait_state(S_SPR, 40, "enter_sprinkle");
    n = 0;
    while (valve_sprinkler && n < 100) begin @(negedge clk); n++; end
    check("sprinkle_len_9_to_12", int'(n >= 9 && n <= 12), 1);
    check("sprinkle_to_soak", int'(state_code), S_SOAK);
    enable = 1'b0;
    n = 0;
    while (int'(state_code) == S_SOAK && n < 100) begin @(negedge clk); n++; end
    check("soak_len_5_to_8", int'(n >= 5 && n <= 8), 1);
    check("soak_to_idle", int'(state_code), S_IDLE);
    check("count_after_sprinkle", int'(cycle_count), 1);

    // Drip cycle
    temp = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_state(S_DRIP, 40, "enter_drip");
    n = 0; seen = 1'b0;
    while (valve_drip && n < 100) begin
      seen |= valve_sprinkler;
      @(negedge clk);
      n++;
    end
    check("drip_len_17_to_20", int'(n >= 17 && n <= 20), 1);
    check("no_sprinkler_in_drip", int'(seen), 0);
    check("drip_to_soak", int'(state_code), S_SOAK);
    enable = 1'b0;
    wait_state(S_IDLE, 20, "drip_soak_idle");
    check("count_after_drip", int'(cycle_count), 2);

    // Low-level abort mid-drip
    {high, middle, low} = 3'b001;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    wait_state(S_DRIP, 40, "enter_drip_low_m");
    repeat (3) @(negedge clk);
    low = 1'b0;
    wait_state(S_IDLE, 20, "low_abort_idle");
    check("low_abort_drip_off", int'(valve_drip), 0);
    check("low_abort_alarm", int'(alarm), 1);
    check("low_abort_count", int'(cycle_count), 2);

    // Fault and recovery
    enable = 1'b0;
    low = 1'b1;
    repeat (8) @(negedge clk);
    {high, middle, low} = 3'b101;
    wait_state(S_FAULT, 40, "enter_fault");
    check("fault_flag", int'(fault), 1);
    check("fault_valves", int'({valve_sprinkler, valve_drip, valve_inlet}), 0);
    check("fault_alarm", int'(alarm), 1);
    middle = 1'b1;
    wait_state(S_IDLE, 40, "fault_exit");
    check("fault_cleared", int'(fault), 0);

    // Inlet hysteresis
    {high, middle, low} = 3'b001;
    wait_inlet(1'b1, 20, "inlet_set");
    {high, middle, low} = 3'b011;
    repeat (12) @(negedge clk);
    check("inlet_hold", int'(valve_inlet), 1);
    high = 1'b1;
    wait_inlet(1'b0, 20, "inlet_clear");

    // Randomised traffic, with occasional asynchronous reset pulses
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 99) < 85) lv = pats[$urandom_range(0, 3)];
      else                            lv = 3'($urandom_range(0, 7));
      {high, middle, low} = lv;
      soil   = ($urandom_range(0, 9) < 7);
      temp   = 1'($urandom_range(0, 1));
      air    = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end

    // Saturation of the cycle counter
    {high, middle, low} = 3'b111;
    soil = 1'b1; temp = 1'b0; air = 1'b0; enable = 1'b1;
    n = 0;
    while (cycle_count != 8'd255 && n < 20000) begin @(negedge clk); n++; end
    check("count_reaches_255", int'(cycle_count), 255);
    repeat (60) @(negedge clk);
    check("count_holds_255", int'(cycle_count), 255);

    // Asynchronous reset while a valve is open
    wait_state(S_SPR, 60, "sprinkle_before_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    check("async_reset_state", int'(state_code), S_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
